// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: counter + target tables indexed by pc (optionally hashed with a
// speculative global history), trained by resolved branches, emitting a one-cycle fetch redirect.
module gshare_branch_predictor #(
    parameter int PC_W   = 8,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 2,
    parameter int GHR_W  = 4,
    parameter int MODE   = 1,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic [PC_W-1:0]   upd_pc_plus1,
    output logic              mispredict,
    output logic [PC_W-1:0]   corrected_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

    logic [CNT_W-1:0]  cnt_q [DEPTH];
    logic [CNT_W-1:0]  cnt_d [DEPTH];
    logic [PC_W-1:0]   tgt_q [DEPTH];
    logic [PC_W-1:0]   tgt_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic              mispredict_q, mispredict_d;
    logic [PC_W-1:0]   corrected_pc_q, corrected_pc_d;
    logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;
    logic [IDX_W-1:0]  idx_f, idx_u;
    logic [CNT_W-1:0]  cnt_u;
    logic              hit_f, mp;

    always_comb begin
        idx_f = fetch_pc[IDX_W-1:0] ^ ((MODE != 0) ? IDX_W'(ghr_q) : '0);
        // training uses the history snapshot that travelled with the branch, not the live GHR
        idx_u = upd_pc[IDX_W-1:0] ^ ((MODE != 0) ? IDX_W'(upd_ghr) : '0);
        hit_f = fetch_valid & ~stall & vld_q[idx_f];
        pred_taken = hit_f & cnt_q[idx_f][CNT_W-1];
        pred_target = pred_taken ? tgt_q[idx_f] : '0;
        pred_ghr = ghr_q;
        mp = upd_valid & ((upd_taken != upd_pred_taken)
                        | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
        ghr_d = mp ? GHR_W'({upd_ghr, upd_taken}) : hit_f ? GHR_W'({ghr_q, pred_taken}) : ghr_q;
        cnt_u = cnt_q[idx_u];
        cnt_d = cnt_q;
        tgt_d = tgt_q;
        vld_d = vld_q;
        if (upd_valid) begin
            cnt_d[idx_u] = upd_taken ? ((cnt_u == CNT_MAX) ? cnt_u : cnt_u + 1'b1)
                                     : ((cnt_u == '0) ? cnt_u : cnt_u - 1'b1);
            if (upd_taken) begin
                tgt_d[idx_u] = upd_target;
                vld_d[idx_u] = 1'b1;
            end
        end
        mispredict_d = mp;
        corrected_pc_d = mp ? (upd_taken ? upd_target : upd_pc_plus1) : corrected_pc_q;
        stat_branches_d = (&stat_branches_q) ? stat_branches_q : stat_branches_q + STAT_W'(upd_valid);
        stat_mispred_d = (&stat_mispred_q) ? stat_mispred_q : stat_mispred_q + STAT_W'(mp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
                tgt_q[i] <= '0;
            end
            vld_q <= '0;
            ghr_q <= '0;
            mispredict_q <= 1'b0;
            corrected_pc_q <= '0;
            stat_branches_q <= '0;
            stat_mispred_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            vld_q <= vld_d;
            ghr_q <= ghr_d;
            mispredict_q <= mispredict_d;
            corrected_pc_q <= corrected_pc_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    assign mispredict = mispredict_q;
    assign corrected_pc = corrected_pc_q;
    assign stat_branches = stat_branches_q;
    assign stat_mispred = stat_mispred_q;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: gshare instance and a bimodal instance with narrow stats,
// both driven by the same stimulus and compared against a table-level reference model.
module tb_gshare_branch_predictor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall, fetch_valid, upd_valid, upd_pred_taken, upd_taken;
    logic [7:0] fetch_pc, upd_pc, upd_pred_target, upd_target, upd_pc_plus1;
    logic [3:0] upd_ghr;
    logic pt0, pt1, mp0, mp1;
    logic [7:0] ptg0, ptg1, cp0, cp1;
    logic [3:0] pg0, pg1, sb1, sm1;
    logic [15:0] sb0, sm0;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.MODE(1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pt0), .pred_target(ptg0), .pred_ghr(pg0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pc_plus1(upd_pc_plus1), .mispredict(mp0), .corrected_pc(cp0),
        .stat_branches(sb0), .stat_mispred(sm0));

    gshare_branch_predictor #(.MODE(0), .STAT_W(4)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pt1), .pred_target(ptg1), .pred_ghr(pg1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pc_plus1(upd_pc_plus1), .mispredict(mp1), .corrected_pc(cp1),
        .stat_branches(sb1), .stat_mispred(sm1));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // reference model: index 0 = gshare instance, 1 = bimodal instance
    int m_cnt[2][256];
    bit m_vld[2][256];
    int m_tgt[2][256];
    int m_ghr[2];
    int m_br[2];
    int m_mpc[2];
    int smax[2] = '{65535, 15};
    int e_mp, e_corr;

    function automatic int m_idx(int m, int pc, int g);
        return (m == 0) ? ((pc ^ g) & 255) : (pc & 255);
    endfunction

    function automatic bit m_hit(int m);
        return fetch_valid && !stall && m_vld[m][m_idx(m, int'(fetch_pc), m_ghr[m])];
    endfunction

    function automatic bit m_pred(int m);
        return m_hit(m) && m_cnt[m][m_idx(m, int'(fetch_pc), m_ghr[m])] >= 2;
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                m_cnt[m][i] = 1;
                m_vld[m][i] = 0;
                m_tgt[m][i] = 0;
            end
            m_ghr[m] = 0;
            m_br[m] = 0;
            m_mpc[m] = 0;
        end
        e_mp = 0;
        e_corr = 0;
    endtask

    task automatic m_edge();
        bit mp, hit, p;
        int u;
        mp = upd_valid && ((upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_pred_taken && upd_target != upd_pred_target));
        for (int m = 0; m < 2; m++) begin
            hit = m_hit(m);
            p = m_pred(m);
            u = m_idx(m, int'(upd_pc), int'(upd_ghr));
            if (mp) m_ghr[m] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 16;
            else if (hit) m_ghr[m] = (m_ghr[m] * 2 + int'(p)) % 16;
            if (upd_valid) begin
                m_cnt[m][u] = upd_taken ? ((m_cnt[m][u] < 3) ? m_cnt[m][u] + 1 : 3)
                                        : ((m_cnt[m][u] > 0) ? m_cnt[m][u] - 1 : 0);
                if (upd_taken) begin
                    m_tgt[m][u] = int'(upd_target);
                    m_vld[m][u] = 1;
                end
            end
            if (upd_valid && m_br[m] < smax[m]) m_br[m]++;
            if (mp && m_mpc[m] < smax[m]) m_mpc[m]++;
        end
        e_mp = int'(mp);
        if (mp) e_corr = upd_taken ? int'(upd_target) : int'(upd_pc_plus1);
    endtask

    task automatic check_comb();
        for (int m = 0; m < 2; m++) begin
            bit p;
            p = m_pred(m);
            chk($sformatf("m%0d pred_taken", m), int'(m == 0 ? pt0 : pt1), int'(p));
            chk($sformatf("m%0d pred_target", m), int'(m == 0 ? ptg0 : ptg1),
                p ? m_tgt[m][m_idx(m, int'(fetch_pc), m_ghr[m])] : 0);
            chk($sformatf("m%0d pred_ghr", m), int'(m == 0 ? pg0 : pg1), m_ghr[m]);
        end
    endtask

    task automatic check_reg();
        chk("m0 mispredict", int'(mp0), e_mp);
        chk("m1 mispredict", int'(mp1), e_mp);
        chk("m0 corrected_pc", int'(cp0), e_corr);
        chk("m1 corrected_pc", int'(cp1), e_corr);
        chk("m0 stat_branches", int'(sb0), m_br[0]);
        chk("m0 stat_mispred", int'(sm0), m_mpc[0]);
        chk("m1 stat_branches", int'(sb1), m_br[1]);
        chk("m1 stat_mispred", int'(sm1), m_mpc[1]);
    endtask

    task automatic idle();
        stall = 0; fetch_valid = 0; fetch_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_ghr = 0; upd_pred_taken = 0;
        upd_pred_target = 0; upd_taken = 0; upd_target = 0; upd_pc_plus1 = 0;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_comb();
        m_edge();
        @(posedge clk);
        #1;
        check_reg();
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        m_reset();
        @(posedge clk);
        #1;
        check_reg();
        reset = 0;
    endtask

    typedef struct {
        bit fv; int pc;
        bit uv; int upc; bit upt; int uptg; bit ut; int utg; int upc1;
        bit e_pt; int e_tg; bit e_mp; int e_cp;
    } vec_t;
    vec_t tbl[11];
    logic [7:0] pcs[8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h3f, 8'h00, 8'hff};
    logic [7:0] tgts[3] = '{8'h40, 8'h41, 8'h80};

    initial begin
        // expectations below are for the bimodal instance
        tbl[0]  = '{1, 'h10, 0, 0,     0, 0,     0, 0,     0,     0, 0,     0, 0};
        tbl[1]  = '{0, 0,    1, 'h10,  0, 0,     1, 'h40,  'h11,  0, 0,     1, 'h40};
        tbl[2]  = '{0, 0,    1, 'h10,  1, 'h40,  1, 'h40,  'h11,  0, 0,     0, 'h40};
        tbl[3]  = '{1, 'h10, 0, 0,     0, 0,     0, 0,     0,     1, 'h40,  0, 'h40};
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[2];
        tbl[6]  = tbl[2];
        tbl[7]  = '{0, 0,    1, 'h10,  1, 'h40,  0, 0,     'h11,  0, 0,     1, 'h11};
        tbl[8]  = '{1, 'h10, 0, 0,     0, 0,     0, 0,     0,     1, 'h40,  0, 'h11};
        tbl[9]  = tbl[7];
        tbl[10] = '{1, 'h10, 0, 0,     0, 0,     0, 0,     0,     0, 0,     0, 'h11};

        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reg();
        reset = 0;

        foreach (tbl[k]) begin
            idle();
            fetch_valid = tbl[k].fv; fetch_pc = 8'(tbl[k].pc);
            upd_valid = tbl[k].uv; upd_pc = 8'(tbl[k].upc);
            upd_pred_taken = tbl[k].upt; upd_pred_target = 8'(tbl[k].uptg);
            upd_taken = tbl[k].ut; upd_target = 8'(tbl[k].utg); upd_pc_plus1 = 8'(tbl[k].upc1);
            @(negedge clk);
            check_comb();
            chk($sformatf("vec%0d pred_taken", k), int'(pt1), int'(tbl[k].e_pt));
            chk($sformatf("vec%0d pred_target", k), int'(ptg1), tbl[k].e_tg);
            m_edge();
            @(posedge clk);
            #1;
            check_reg();
            chk($sformatf("vec%0d mispredict", k), int'(mp1), int'(tbl[k].e_mp));
            chk($sformatf("vec%0d corrected_pc", k), int'(cp1), tbl[k].e_cp);
        end
        idle();
        run_cycle();
        chk("stat_mispred after vectors", int'(sm1), 3);

        // repair must beat a same-cycle speculative shift
        do_reset();
        upd_valid = 1; upd_pc = 8'h20; upd_taken = 1; upd_target = 8'h50;
        run_cycle();
        idle();
        fetch_valid = 1; fetch_pc = 8'h21;
        upd_valid = 1; upd_pc = 8'h33; upd_ghr = 4'b0110; upd_taken = 1; upd_target = 8'h60;
        @(negedge clk);
        chk("ghr repair spec hit", int'(pt0), 1);
        check_comb();
        m_edge();
        @(posedge clk);
        #1;
        check_reg();
        chk("ghr repair m0", int'(pg0), 'hd);
        chk("ghr repair m1", int'(pg1), 'hd);

        // reset while a redirect is pending
        idle();
        upd_valid = 1; upd_pc = 8'h10; upd_taken = 1; upd_target = 8'h44;
        run_cycle();
        chk("pending redirect", int'(mp0), 1);
        idle();
        reset = 1;
        #1;
        m_reset();
        check_reg();
        chk("reset drops redirect", int'(mp0), 0);
        @(posedge clk);
        #1;
        reset = 0;
        fetch_valid = 1; fetch_pc = 8'h20;
        @(negedge clk);
        chk("reset clears table", int'(pt1), 0);
        check_comb();
        m_edge();
        @(posedge clk);
        #1;
        check_reg();

        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 7);
            fetch_valid = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            fetch_pc = ($urandom_range(0, 1) == 1) ? 8'(int'(pcs[k]) ^ m_ghr[0]) : pcs[k];
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc = pcs[$urandom_range(0, 7)];
            upd_ghr = 4'($urandom_range(0, 15));
            upd_taken = 1'($urandom_range(0, 1));
            upd_pred_taken = 1'($urandom_range(0, 1));
            upd_target = tgts[$urandom_range(0, 2)];
            upd_pred_target = tgts[$urandom_range(0, 2)];
            upd_pc_plus1 = upd_pc + 8'd1;
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
